// File: rtl/sha1_core_mb.sv
// Multi-block SHA-1 compression core: ROUNDS_PER_CYCLE chained rounds per clock, in-place W schedule.
// Optional abort input enabled by defining SHA1_ABORT_EN.

module sha1_round (
  input  logic [6:0]   t,
  input  logic [31:0]  w,
  input  logic [159:0] st_in,
  output logic [159:0] st_out
);
  logic [31:0] a, b, c, d, e, f, k, tmp;

  assign {a, b, c, d, e} = st_in;

  // f/K follow the true round index so a cycle may straddle a stage boundary
  always_comb begin
    f = b ^ c ^ d;
    k = 32'hca62c1d6;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5a827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ed9eba1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8f1bbcdc;
    end
  end

  assign tmp    = {a[26:0], a[31:27]} + f + e + k + w;
  assign st_out = {tmp, a, {b[1:0], b[31:2]}, c, d};
endmodule

module sha1_core_mb #(
  parameter int ROUNDS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [159:0] digest,
  output logic         busy
`ifdef SHA1_ABORT_EN
  ,
  input  logic         abort
`endif
);
  localparam int R    = ROUNDS_PER_CYCLE;
  localparam int NCYC = 80 / R;
  localparam logic [6:0]   RND_END = 7'(NCYC * R);
  localparam logic [159:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                 32'h10325476, 32'hc3d2e1f0};

  if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : g_bad_r
    $error("sha1_core_mb: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;
  state_t state, state_nx;

  logic               abort_i;
  logic [15:0][31:0]  wbuf;
  logic [6:0]         rnd;
  logic               last_q;
  logic [159:0]       hs, work, hnew;
  logic [159:0]       chain [R+1];
  logic [31:0]        wr    [R];
  logic [6:0]         tj    [R];

`ifdef SHA1_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign chain[0] = work;

  for (genvar j = 0; j < R; j++) begin : g_lane
    logic [3:0]  ix;
    logic [31:0] w3, wx;

    assign tj[j] = rnd + 7'(j);
    assign ix    = tj[j][3:0];
    // W[t-3] may have been produced earlier in this same cycle
    if (j >= 3) begin : g_fwd
      assign w3 = wr[j-3];
    end else begin : g_buf
      assign w3 = wbuf[ix - 4'd3];
    end
    assign wx    = w3 ^ wbuf[ix - 4'd8] ^ wbuf[ix - 4'd14] ^ wbuf[ix];
    assign wr[j] = (tj[j] < 7'd16) ? wbuf[ix] : {wx[30:0], wx[31]};

    sha1_round u_round (
      .t      (tj[j]),
      .w      (wr[j]),
      .st_in  (chain[j]),
      .st_out (chain[j+1])
    );
  end

  always_comb begin
    hnew = '0;
    for (int i = 0; i < 5; i++) hnew[32*i +: 32] = hs[32*i +: 32] + work[32*i +: 32];
  end

  assign blk_ready    = (state == S_IDLE) && !abort_i;
  assign busy         = (state != S_IDLE);
  assign digest_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // The counter saturates at RND_END; ROUND exits one cycle later so FINAL is entered once
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (blk_valid && blk_ready) state_nx = S_ROUND;
      S_ROUND: if (rnd == RND_END) state_nx = S_FINAL;
      S_FINAL: state_nx = last_q ? S_DONE : S_IDLE;
      S_DONE:  if (digest_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_i) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd    <= '0;
      hs     <= IV;
      work   <= '0;
      wbuf   <= '0;
      last_q <= 1'b0;
      digest <= '0;
    end else if (abort_i) begin
      hs <= IV;
    end else begin
      case (state)
        S_IDLE: if (blk_valid) begin
          for (int i = 0; i < 16; i++) wbuf[i] <= blk_data[511-32*i -: 32];
          last_q <= blk_last;
          rnd    <= '0;
          if (blk_first) begin
            hs   <= IV;
            work <= IV;
          end else begin
            work <= hs;
          end
        end
        S_ROUND: if (rnd != RND_END) begin
          work <= chain[R];
          rnd  <= rnd + 7'(R);
          for (int j = 0; j < R; j++) wbuf[tj[j][3:0]] <= wr[j];
        end
        S_FINAL: begin
          hs <= hnew;
          if (last_q) digest <= hnew;
        end
        default: ;
      endcase
    end
  end
endmodule
